// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NREQ byte sources, one byte per grant,
// round-robin order, and sequences the tx_start / tx_done_tick handshake.
// Optional watchdog abort of a transfer whose tx_done_tick never arrives:
// compile with TX_TIMEOUT_EN defined.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned DBIT    = 8,
    parameter int unsigned TIMEOUT = 100000000,
    parameter int unsigned TO_W    = 27
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DBIT-1:0] req_data,
    output logic [NREQ-1:0]      ack,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 tx_start,
    output logic [DBIT-1:0]      tx_din,
    input  logic                 tx_done_tick,
    output logic                 timeout_err
);

    // Elaboration-time parameter sanity checks
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("uart_tx_arbiter: NREQ must be in 2..8");
    end
    if ((64'd1 << TO_W) <= 64'(TIMEOUT)) begin : g_bad_to_w
        $error("uart_tx_arbiter: 2**TO_W must exceed TIMEOUT");
    end

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWait,
        StDone
    } state_e;

    state_e          state;
    logic [2:0]      ptr;
    logic [NREQ-1:0] rot;
    logic            sel_found;
    logic [3:0]      sel_sum;
    logic [2:0]      sel_idx;
    logic [2:0]      next_ptr;
    logic [DBIT-1:0] grant_data;
    logic [NREQ-1:0] ack_set;

`ifdef TX_TIMEOUT_EN
    logic [TO_W-1:0] wait_cnt;
`endif

    // Rotate requests so bit 0 is the requester at ptr, then take the first set bit
    always_comb begin
        rot       = NREQ'({req, req} >> ptr);
        sel_found = 1'b0;
        sel_sum   = 4'd0;
        for (int j = 0; j < NREQ; j++) begin
            if (!sel_found && rot[j]) begin
                sel_found = 1'b1;
                sel_sum   = {1'b0, ptr} + 4'(j);
            end
        end
        if (sel_sum >= 4'(NREQ)) begin
            sel_sum = sel_sum - 4'(NREQ);
        end
        sel_idx = sel_sum[2:0];
    end

    // Data mux, ack one-hot and pointer advance for the granted requester
    always_comb begin
        grant_data = '0;
        ack_set    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == 3'(i)) begin
                grant_data = req_data[i*DBIT +: DBIT];
                ack_set[i] = 1'b1;
            end
        end
        next_ptr = (grant_id == 3'(NREQ - 1)) ? 3'd0 : grant_id + 3'd1;
    end

    // Arbitration FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            ptr      <= 3'd0;
            grant_id <= 3'd0;
            ack      <= '0;
            busy     <= 1'b0;
            tx_start <= 1'b0;
            tx_din   <= '0;
`ifdef TX_TIMEOUT_EN
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            ack      <= '0;
            tx_start <= 1'b0;
`ifdef TX_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                StIdle: begin
                    if (sel_found) begin
                        grant_id <= sel_idx;
                        busy     <= 1'b1;
                        state    <= StLoad;
                    end
                end
                StLoad: begin
                    tx_din <= grant_data;
                    state  <= StStart;
                end
                StStart: begin
                    // Pulse is registered, so uart_tx sees it during the first WAIT cycle
                    tx_start <= 1'b1;
`ifdef TX_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state    <= StWait;
                end
                StWait: begin
                    // A done tick coinciding with our own tx_start cannot belong to this byte
                    if (tx_done_tick && !tx_start) begin
                        ack   <= ack_set;
                        state <= StDone;
                    end
`ifdef TX_TIMEOUT_EN
                    else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        ptr         <= next_ptr;
                        busy        <= 1'b0;
                        state       <= StIdle;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                StDone: begin
                    ptr   <= next_ptr;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

`ifndef TX_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single byte, round-robin, data capture,
// spurious done ticks, async reset mid-transfer, lone requester, optional watchdog.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [23:0] req_data;
    logic [2:0]  ack;
    logic        busy;
    logic [2:0]  grant_id;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        tx_done_tick;
    logic        timeout_err;

    int vectors;
    int miscompares;

    uart_tx_arbiter #(
        .NREQ    (3),
        .DBIT    (8),
        .TIMEOUT (50),
        .TO_W    (27)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .busy         (busy),
        .grant_id     (grant_id),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    // One full byte, entered at a negedge in IDLE with req already driven
    task automatic xfer(input logic [2:0] exp_id, input logic [7:0] exp_data, input int dly);
        tick(1);
        chk("grant_id", 32'(grant_id), 32'(exp_id));
        chk("busy_load", 32'(busy), 32'd1);
        tick(1);
        chk("tx_din", 32'(tx_din), 32'(exp_data));
        chk("tx_start_pre", 32'(tx_start), 32'd0);
        tick(1);
        chk("tx_start", 32'(tx_start), 32'd1);
        tick(1);
        chk("tx_start_pulse", 32'(tx_start), 32'd0);
        tick(dly);
        chk("ack_wait", 32'(ack), 32'd0);
        chk("busy_wait", 32'(busy), 32'd1);
        tx_done_tick = 1'b1;
        tick(1);
        tx_done_tick = 1'b0;
        chk("ack", 32'(ack), 32'd1 << exp_id);
        tick(1);
        chk("ack_clear", 32'(ack), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        req          = 3'b000;
        req_data     = 24'h0;
        tx_done_tick = 1'b0;

        // Reset state
        tick(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_din", 32'(tx_din), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        tick(1);

        // Single request, done 20 cycles after tx_start
        req      = 3'b001;
        req_data = 24'h000041;
        xfer(3'd0, 8'h41, 20);
        req = 3'b000;
        tick(1);
        chk("single_idle", 32'(busy), 32'd0);

        // Spurious done tick while idle
        tx_done_tick = 1'b1;
        tick(2);
        chk("spur_idle_ack", 32'(ack), 32'd0);
        chk("spur_idle_busy", 32'(busy), 32'd0);
        tx_done_tick = 1'b0;

        // Round-robin from ptr=0 with all requesters held
        do_reset();
        req      = 3'b111;
        req_data = 24'h333231;
        xfer(3'd0, 8'h31, 3);
        xfer(3'd1, 8'h32, 3);
        xfer(3'd2, 8'h33, 3);
        xfer(3'd0, 8'h31, 3);
        req = 3'b000;
        tick(1);

        // Data change after LOAD (ptr now 1)
        req      = 3'b010;
        req_data = 24'h005500;
        tick(1);
        chk("dc_grant", 32'(grant_id), 32'd1);
        tick(1);
        chk("dc_din", 32'(tx_din), 32'h55);
        tick(1);
        chk("dc_start", 32'(tx_start), 32'd1);
        req_data = 24'h00AA00;
        tick(3);
        chk("dc_din_hold", 32'(tx_din), 32'h55);
        tx_done_tick = 1'b1;
        tick(1);
        tx_done_tick = 1'b0;
        chk("dc_ack", 32'(ack), 32'b010);
        req = 3'b000;
        tick(1);
        chk("dc_idle", 32'(busy), 32'd0);

        // Spurious done tick during START (ptr now 2)
        req      = 3'b100;
        req_data = 24'h770000;
        tick(2);
        chk("ss_din", 32'(tx_din), 32'h77);
        tx_done_tick = 1'b1;
        tick(1);
        tx_done_tick = 1'b0;
        chk("ss_start", 32'(tx_start), 32'd1);
        chk("ss_ack0", 32'(ack), 32'd0);
        tick(1);
        chk("ss_ack1", 32'(ack), 32'd0);
        chk("ss_busy", 32'(busy), 32'd1);
        tx_done_tick = 1'b1;
        tick(1);
        tx_done_tick = 1'b0;
        chk("ss_ack", 32'(ack), 32'b100);
        req = 3'b000;
        tick(1);
        chk("ss_idle", 32'(busy), 32'd0);

        // Async reset while tx_start is high in WAIT, then served from ptr=0
        req      = 3'b001;
        req_data = 24'h006611;
        tick(1);
        chk("ar_grant", 32'(grant_id), 32'd0);
        tick(2);
        chk("ar_start", 32'(tx_start), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_tx_start", 32'(tx_start), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_ack", 32'(ack), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        req   = 3'b010;
        xfer(3'd1, 8'h66, 5);
        req = 3'b000;
        tick(1);

        // Lone requester served back-to-back
        req      = 3'b100;
        req_data = 24'h5A0000;
        xfer(3'd2, 8'h5A, 4);
        xfer(3'd2, 8'h5A, 4);
        req = 3'b000;
        tick(2);

`ifdef TX_TIMEOUT_EN
        // Watchdog: no done tick, abort then move on to the next requester
        do_reset();
        req      = 3'b011;
        req_data = 24'h002221;
        tick(3);
        chk("to_start", 32'(tx_start), 32'd1);
        tick(49);
        chk("to_early", 32'(timeout_err), 32'd0);
        tick(1);
        chk("to_pulse", 32'(timeout_err), 32'd1);
        chk("to_ack", 32'(ack), 32'd0);
        chk("to_busy", 32'(busy), 32'd0);
        tick(1);
        chk("to_next_grant", 32'(grant_id), 32'd1);
        chk("to_pulse_end", 32'(timeout_err), 32'd0);
        req = 3'b000;
        tick(2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
